ram2e_efb_responder: RTL and testbench
======================================

Name: ram2e_efb_responder

Overview:
- Wishbone responder that emulates the MachXO2 EFB configuration port on the UFM side: frame control, command/operand/data bytes, and read-data return.
- Backs a small byte-addressed UFM page store.
- Used as the bench model for the UFM initiator.
- Also serves as a drop-in settings store on RAM2E targets without an EFB, so the existing boot-time UFM load sequence runs unchanged.

Parameters:
PAGES, 4, number of 16-byte UFM pages held; page index = ufm_addr mod PAGES (power of 2)
INIT_PAGE, 2, page preloaded at power-up with INIT_B0/INIT_B1 (all other bytes 0xFF)
INIT_B0, 8'hFF, power-up byte 0 of INIT_PAGE (RAMWorks mask)
INIT_B1, 8'h01, power-up byte 1 of INIT_PAGE (LED enable)
BUSY_CYCLES, 16, C14M cycles busy after a page-write commit

Ports:
C14M  in  1  clock
nRST  in  1  synchronous active-low reset
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  1 = write
wb_adr_i  in  8  register address
wb_dat_i  in  8  write data
wb_dat_o  out  8  read data, valid with ack
wb_ack_o  out  1  single-cycle acknowledge
cfg_en  out  1  configuration interface enabled
busy  out  1  page-write in progress
ufm_addr  out  14  current UFM page address

Behaviour:
- Reset: one clock; nRST is synchronous and active-low, sampled on C14M rising edge.
  - Values on reset: wb_ack_o=0, wb_dat_o=0, cfg_en=0, busy=0, ufm_addr=0; frame closed, byte counter 0, read pointer 0, staging discarded.
  - The page store is not reset (non-volatile); it is initialised only at power-up.
  - Reset mid-transaction drops ack and discards the open frame.
- Handshake:
  - Request is cyc_i&stb_i&!ack_o sampled at edge N; ack_o=1 for exactly one cycle at N+1, then low for at least one cycle. No back-to-back acks.
  - All addresses are acked. Side effects happen on the edge that raises ack.
- Registers:
  - 0x70 write: bit7=1 opens the frame and clears the byte counter and read pointer; bit7=0 closes it and runs the commit step.
  - 0x71 write, frame open: byte counter k (5-bit, saturating at 31) selects the byte: 0 = opcode, 1..3 = operands, 4+ = data. Ignored when the frame is closed.
  - 0x73 read: returns the next response byte of the active command, else 0x00.
  - All other reads return 0x00; all other writes are ignored.
- Opcodes (acted on when the byte that completes them is written):
  - 0x74: cfg_en<=1 at k=3.
  - 0x26: cfg_en<=0 at k=2.
  - 0xFF: no-op.
  - 0x3C (status): reads return a 32-bit big-endian word, bytes 0..3. Bit12 = busy (byte2 bit4); all other bits 0.
  - 0xB4: at k=7, ufm_addr <= {byte6[5:0], byte7}; byte4/byte5 ignored.
  - 0xCA (read page): each 0x73 read returns page[ufm_addr mod PAGES][ptr], then ptr++. When ptr wraps 15->0, ufm_addr increments (14-bit wrap).
  - 0xC9 (write page): data bytes k=4..19 go to a 16-byte staging buffer.
    - At frame close with exactly 16 data bytes: copy staging to the page, ufm_addr++, busy=1 for BUSY_CYCLES cycles.
    - Any other data count: staging discarded, nothing written.
- Gating:
  - With cfg_en=0, only 0x74, 0xFF and 0x3C act; others are ignored, and 0x73 returns 0x00.
  - While busy, 0xB4/0xCA/0xC9 are ignored; 0x3C still works.
  - A new open frame while one is already open restarts the counter and discards staging.
  - A commit coinciding with reset loses the commit (reset wins).

Decomposition:
- Package ram2e_efb_pkg: register addresses (CFGCR 0x70, CFGTXDR 0x71, CFGRXDR 0x73), opcodes (0x74, 0x26, 0xFF, 0x3C, 0xB4, 0xCA, 0xC9), status busy bit index 12, page size 16.
- Sub-module ram2e_ufm_page_store holds the PAGES×16 byte array:
  - one async read port (page, byte);
  - one 16-byte write port (page, staging, strobe);
  - power-up init from the INIT_* parameters.

Test Plan:
- Power-up, full boot sequence (enable 0x74/08/00/00; status poll; set address 0x40,00,00,190; read page 0xCA/10/00/01, 16 reads) -> first read 0xFF, second read 0x01, remaining reads 0xFF; each ack exactly one cycle after stb.
- Write page: address 190, 0xC9 + 16 bytes 0x00..0x0F, close -> busy high for 16 cycles; status byte2=0x10 during busy, 0x00 after. Read back of page 190 gives 0x00..0x0F; ufm_addr = 191 after the commit.
- Short write: 0xC9 with 15 data bytes, close -> page unchanged, busy stays 0.
- cfg_en=0: 0xCA then read 0x73 -> 0x00; 0xB4 ignored, ufm_addr unchanged.
- 17 consecutive 0x73 reads under 0xCA -> the 17th read returns byte 0 of page ufm_addr+1.
- nRST low mid-frame with ack pending -> next cycle ack=0, cfg_en=0, ufm_addr=0; page contents preserved.

Source files
------------

// File: rtl/ram2e_efb_pkg.sv
// Shared constants for the RAM2E EFB configuration-port responder:
// Wishbone register map, UFM command opcodes and frame byte positions.
package ram2e_efb_pkg;

  localparam logic [7:0] CFGCR   = 8'h70;
  localparam logic [7:0] CFGTXDR = 8'h71;
  localparam logic [7:0] CFGRXDR = 8'h73;

  localparam logic [7:0] OP_ENABLE     = 8'h74;
  localparam logic [7:0] OP_DISABLE    = 8'h26;
  localparam logic [7:0] OP_NOP        = 8'hFF;
  localparam logic [7:0] OP_STATUS     = 8'h3C;
  localparam logic [7:0] OP_SET_ADDR   = 8'hB4;
  localparam logic [7:0] OP_READ_PAGE  = 8'hCA;
  localparam logic [7:0] OP_WRITE_PAGE = 8'hC9;

  localparam int STATUS_BUSY_BIT = 12;
  localparam int PAGE_BYTES      = 16;
  localparam int PAGE_BITS       = PAGE_BYTES * 8;

  // Frame byte counter positions: opcode at 0, operands 1..3, data from 4.
  localparam logic [4:0] K_DISABLE    = 5'd2;
  localparam logic [4:0] K_ENABLE     = 5'd3;
  localparam logic [4:0] K_FIRST_DATA = 5'd4;
  localparam logic [4:0] K_ADDR_HI    = 5'd6;
  localparam logic [4:0] K_ADDR_LO    = 5'd7;
  localparam logic [4:0] K_PAGE_FULL  = 5'd20;
  localparam logic [4:0] K_SAT        = 5'd31;

  typedef enum logic {
    FRAME_CLOSED = 1'b0,
    FRAME_OPEN   = 1'b1
  } frame_state_e;

  function automatic int page_index_bits(input int pages);
    return (pages > 1) ? $clog2(pages) : 1;
  endfunction

  // Status is a big-endian 32-bit word; idx 0 is the most significant byte.
  function automatic logic [7:0] status_byte(input logic [1:0] idx, input logic busy_bit);
    logic [31:0] word;
    word = '0;
    word[STATUS_BUSY_BIT] = busy_bit;
    return word[8 * (3 - int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/ram2e_ufm_page_store.sv
// Byte-addressed UFM page array: asynchronous byte read, whole-page write,
// contents set only at power-up and never cleared by reset.
module ram2e_ufm_page_store
  import ram2e_efb_pkg::*;
#(
  parameter int          PAGES     = 4,
  parameter int          INIT_PAGE = 2,
  parameter logic [7:0]  INIT_B0   = 8'hFF,
  parameter logic [7:0]  INIT_B1   = 8'h01,
  localparam int         PW        = page_index_bits(PAGES)
) (
  input  logic                 clk,
  input  logic [PW-1:0]        rd_page,
  input  logic [3:0]           rd_byte,
  output logic [7:0]           rd_data,
  input  logic                 wr_en,
  input  logic [PW-1:0]        wr_page,
  input  logic [PAGE_BITS-1:0] wr_data
);

  localparam int MEM_BITS = PAGES * PAGE_BITS;

  function automatic logic [MEM_BITS-1:0] init_image();
    logic [MEM_BITS-1:0] img;
    img = '1;
    img[PAGE_BITS * (INIT_PAGE % PAGES) +: 8]     = INIT_B0;
    img[PAGE_BITS * (INIT_PAGE % PAGES) + 8 +: 8] = INIT_B1;
    return img;
  endfunction

  // Byte b of page p lives at bits [8*(16p+b) +: 8], matching the staging layout.
  logic [MEM_BITS-1:0] mem = init_image();

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[PAGE_BITS * int'(wr_page) +: PAGE_BITS] <= wr_data;
  end

  assign rd_data = mem[8 * (PAGE_BYTES * int'(rd_page) + int'(rd_byte)) +: 8];

endmodule

// File: rtl/ram2e_efb_responder.sv
// Wishbone responder emulating the MachXO2 EFB UFM configuration port:
// frame control, command bytes, read-data return and a small page store.
module ram2e_efb_responder
  import ram2e_efb_pkg::*;
#(
  parameter int         PAGES       = 4,
  parameter int         INIT_PAGE   = 2,
  parameter logic [7:0] INIT_B0     = 8'hFF,
  parameter logic [7:0] INIT_B1     = 8'h01,
  parameter int         BUSY_CYCLES = 16
) (
  input  logic        C14M,
  input  logic        nRST,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [7:0]  wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o,
  output logic        cfg_en,
  output logic        busy,
  output logic [13:0] ufm_addr
);

  localparam int         PW        = page_index_bits(PAGES);
  localparam logic [15:0] BUSY_LOAD = 16'(BUSY_CYCLES);

  frame_state_e         frame_state;
  frame_state_e         frame_next;
  logic                 req;
  logic                 wr_cr;
  logic                 wr_tx;
  logic                 rd_rx;
  logic                 cmd_active;
  logic                 rx_advance;
  logic                 commit;
  logic [4:0]           k;
  logic [3:0]           ptr;
  logic [7:0]           opcode;
  logic [7:0]           rx_byte;
  logic [7:0]           page_byte;
  logic [5:0]           addr_hi;
  logic [15:0]          busy_cnt;
  logic [PAGE_BITS-1:0] staging;

  assign busy = (busy_cnt != 16'd0);

  always_ff @(posedge C14M) begin
    if (!nRST)
      frame_state <= FRAME_CLOSED;
    else
      frame_state <= frame_next;
  end

  always_comb begin
    req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    wr_cr      = req & wb_we_i & (wb_adr_i == CFGCR);
    wr_tx      = req & wb_we_i & (wb_adr_i == CFGTXDR) & (frame_state == FRAME_OPEN);
    rd_rx      = req & ~wb_we_i & (wb_adr_i == CFGRXDR);
    cmd_active = (frame_state == FRAME_OPEN) && (k != 5'd0);
    rx_byte    = 8'h00;
    rx_advance = 1'b0;
    frame_next = frame_state;

    if (wr_cr)
      frame_next = wb_dat_i[7] ? FRAME_OPEN : FRAME_CLOSED;

    // Only status and an enabled, idle page read produce response bytes.
    if (cmd_active) begin
      case (opcode)
        OP_STATUS: begin
          rx_byte    = (ptr < 4'd4) ? status_byte(ptr[1:0], busy) : 8'h00;
          rx_advance = 1'b1;
        end
        OP_READ_PAGE: begin
          if (cfg_en && !busy) begin
            rx_byte    = page_byte;
            rx_advance = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A page write lands only with exactly 16 data bytes; reset suppresses it.
    commit = nRST && wr_cr && !wb_dat_i[7] && (frame_state == FRAME_OPEN) &&
             (opcode == OP_WRITE_PAGE) && (k == K_PAGE_FULL) && cfg_en && !busy;
  end

  always_ff @(posedge C14M) begin
    if (!nRST) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
      cfg_en   <= 1'b0;
      busy_cnt <= 16'd0;
      ufm_addr <= 14'd0;
      k        <= 5'd0;
      ptr      <= 4'd0;
      opcode   <= OP_NOP;
      addr_hi  <= 6'd0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= rd_rx ? rx_byte : 8'h00;

      if (busy)
        busy_cnt <= busy_cnt - 16'd1;

      if (wr_cr && wb_dat_i[7]) begin
        k   <= 5'd0;
        ptr <= 4'd0;
      end

      if (commit) begin
        ufm_addr <= ufm_addr + 14'd1;
        busy_cnt <= BUSY_LOAD;
      end

      if (wr_tx) begin
        if (k != K_SAT)
          k <= k + 5'd1;
        if (k == 5'd0)
          opcode <= wb_dat_i;
        if (k == K_ADDR_HI)
          addr_hi <= wb_dat_i[5:0];
        if (k == K_ENABLE && opcode == OP_ENABLE)
          cfg_en <= 1'b1;
        if (k == K_DISABLE && opcode == OP_DISABLE && cfg_en)
          cfg_en <= 1'b0;
        if (k == K_ADDR_LO && opcode == OP_SET_ADDR && cfg_en && !busy)
          ufm_addr <= {addr_hi, wb_dat_i};
      end

      // Reading past the last byte of a page rolls over into the next page.
      if (rd_rx && rx_advance) begin
        ptr <= ptr + 4'd1;
        if (opcode == OP_READ_PAGE && ptr == 4'd15)
          ufm_addr <= ufm_addr + 14'd1;
      end
    end
  end

  // Staging is never cleared; a commit needs all 16 slots freshly written anyway.
  always_ff @(posedge C14M) begin
    if (wr_tx && opcode == OP_WRITE_PAGE && k >= K_FIRST_DATA && k < K_PAGE_FULL)
      staging[8 * (int'(k) - int'(K_FIRST_DATA)) +: 8] <= wb_dat_i;
  end

  ram2e_ufm_page_store #(
    .PAGES     (PAGES),
    .INIT_PAGE (INIT_PAGE),
    .INIT_B0   (INIT_B0),
    .INIT_B1   (INIT_B1)
  ) u_store (
    .clk     (C14M),
    .rd_page (ufm_addr[PW-1:0]),
    .rd_byte (ptr),
    .rd_data (page_byte),
    .wr_en   (commit),
    .wr_page (ufm_addr[PW-1:0]),
    .wr_data (staging)
  );

endmodule

// File: tb/tb_ram2e_efb_responder.sv
// Directed bench for ram2e_efb_responder: boot sequence, page write/readback,
// gating, page rollover and reset behaviour, with a read-data scoreboard.
module tb_ram2e_efb_responder;
  import ram2e_efb_pkg::*;

  logic        clk;
  logic        n_rst;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [7:0]  wb_adr;
  logic [7:0]  wb_wdat;
  logic [7:0]  wb_rdat;
  logic        wb_ack;
  logic        cfg_en;
  logic        busy;
  logic [13:0] ufm_addr;

  int          vectors;
  int          miscompares;
  int          busy_cycles;
  int          busy_mark;
  logic [7:0]  exp_q[$];

  ram2e_efb_responder dut (
    .C14M     (clk),
    .nRST     (n_rst),
    .wb_cyc_i (wb_cyc),
    .wb_stb_i (wb_stb),
    .wb_we_i  (wb_we),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_wdat),
    .wb_dat_o (wb_rdat),
    .wb_ack_o (wb_ack),
    .cfg_en   (cfg_en),
    .busy     (busy),
    .ufm_addr (ufm_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges at which busy was high, for the busy-length checks.
  initial busy_cycles = 0;
  always @(posedge clk) begin
    if (busy === 1'b1)
      busy_cycles <= busy_cycles + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One Wishbone transfer: ack must follow one cycle after the request and drop next cycle.
  task automatic applyStimulus(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                               input logic [7:0] exp, input string tag);
    logic [7:0] exp_byte;
    @(negedge clk);
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    wb_we   = we;
    wb_adr  = adr;
    wb_wdat = dat;
    if (!we)
      exp_q.push_back(exp);
    @(posedge clk);
    #1;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    checkOutput({tag, " ack"}, 32'(wb_ack), 32'd1);
    if (!we) begin
      exp_byte = exp_q.pop_front();
      checkOutput(tag, 32'(wb_rdat), 32'(exp_byte));
    end
    @(posedge clk);
    #1;
    checkOutput({tag, " ack drop"}, 32'(wb_ack), 32'd0);
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [7:0] dat);
    applyStimulus(1'b1, adr, dat, 8'h00, "wr");
  endtask

  task automatic rx_read(input logic [7:0] exp, input string tag);
    applyStimulus(1'b0, CFGRXDR, 8'h00, exp, tag);
  endtask

  task automatic open_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c);
    wb_write(CFGCR, 8'h80);
    wb_write(CFGTXDR, op);
    wb_write(CFGTXDR, a);
    wb_write(CFGTXDR, b);
    wb_write(CFGTXDR, c);
  endtask

  task automatic close_frame();
    wb_write(CFGCR, 8'h00);
  endtask

  task automatic set_addr(input logic [13:0] addr);
    open_cmd(OP_SET_ADDR, 8'h00, 8'h00, 8'h00);
    wb_write(CFGTXDR, 8'h40);
    wb_write(CFGTXDR, 8'h00);
    wb_write(CFGTXDR, {2'b00, addr[13:8]});
    wb_write(CFGTXDR, addr[7:0]);
    close_frame();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_rst   = 1'b0;
    wb_cyc  = 1'b0;
    wb_stb  = 1'b0;
    wb_we   = 1'b0;
    wb_adr  = 8'h00;
    wb_wdat = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ack", 32'(wb_ack), 32'd0);
    checkOutput("reset dat", 32'(wb_rdat), 32'd0);
    checkOutput("reset cfg_en", 32'(cfg_en), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ufm_addr", 32'(ufm_addr), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    $display("[TB] boot sequence");
    open_cmd(OP_ENABLE, 8'h08, 8'h00, 8'h00);
    close_frame();
    checkOutput("cfg_en after enable", 32'(cfg_en), 32'd1);
    open_cmd(OP_STATUS, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++)
      rx_read(8'h00, $sformatf("boot status %0d", i));
    close_frame();
    set_addr(14'd190);
    checkOutput("boot ufm_addr", 32'(ufm_addr), 32'd190);
    open_cmd(OP_READ_PAGE, 8'h10, 8'h00, 8'h01);
    for (int i = 0; i < 16; i++)
      rx_read((i == 1) ? 8'h01 : 8'hFF, $sformatf("boot page %0d", i));
    close_frame();
    checkOutput("ufm_addr after page read", 32'(ufm_addr), 32'd191);

    $display("[TB] page write");
    set_addr(14'd190);
    open_cmd(OP_WRITE_PAGE, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++)
      wb_write(CFGTXDR, 8'(i));
    busy_mark = busy_cycles;
    close_frame();
    checkOutput("busy after commit", 32'(busy), 32'd1);
    checkOutput("ufm_addr after commit", 32'(ufm_addr), 32'd191);
    wb_write(CFGCR, 8'h80);
    wb_write(CFGTXDR, OP_STATUS);
    rx_read(8'h00, "busy status b0");
    rx_read(8'h00, "busy status b1");
    rx_read(8'h10, "busy status b2");
    rx_read(8'h00, "busy status b3");
    close_frame();
    repeat (20) @(posedge clk);
    #1;
    checkOutput("busy after wait", 32'(busy), 32'd0);
    checkOutput("busy length", 32'(busy_cycles - busy_mark), 32'd16);
    wb_write(CFGCR, 8'h80);
    wb_write(CFGTXDR, OP_STATUS);
    rx_read(8'h00, "idle status b0");
    rx_read(8'h00, "idle status b1");
    rx_read(8'h00, "idle status b2");
    close_frame();

    $display("[TB] page rollover and readback");
    set_addr(14'd189);
    open_cmd(OP_READ_PAGE, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++)
      rx_read(8'hFF, $sformatf("page189 %0d", i));
    checkOutput("ufm_addr rollover", 32'(ufm_addr), 32'd190);
    for (int i = 0; i < 16; i++)
      rx_read(8'(i), $sformatf("page190 %0d", i));
    checkOutput("ufm_addr second rollover", 32'(ufm_addr), 32'd191);
    close_frame();

    $display("[TB] short write");
    set_addr(14'd190);
    open_cmd(OP_WRITE_PAGE, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 15; i++)
      wb_write(CFGTXDR, 8'hA0 + 8'(i));
    busy_mark = busy_cycles;
    close_frame();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("short busy", 32'(busy_cycles - busy_mark), 32'd0);
    checkOutput("short ufm_addr", 32'(ufm_addr), 32'd190);
    open_cmd(OP_READ_PAGE, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++)
      rx_read(8'(i), $sformatf("short readback %0d", i));
    close_frame();

    $display("[TB] cfg disabled");
    open_cmd(OP_DISABLE, 8'h00, 8'h00, 8'h00);
    close_frame();
    checkOutput("cfg_en after disable", 32'(cfg_en), 32'd0);
    open_cmd(OP_READ_PAGE, 8'h00, 8'h00, 8'h00);
    rx_read(8'h00, "disabled read");
    close_frame();
    set_addr(14'd5);
    checkOutput("disabled set addr", 32'(ufm_addr), 32'd191);
    applyStimulus(1'b0, 8'h10, 8'h00, 8'h00, "other reg read");

    $display("[TB] held strobe");
    @(negedge clk);
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we  = 1'b0;
    wb_adr = 8'h10;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("held ack %0d", i), 32'(wb_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset mid frame");
    open_cmd(OP_ENABLE, 8'h08, 8'h00, 8'h00);
    close_frame();
    set_addr(14'd190);
    wb_write(CFGCR, 8'h80);
    wb_write(CFGTXDR, OP_READ_PAGE);
    @(negedge clk);
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we  = 1'b0;
    wb_adr = CFGRXDR;
    n_rst  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst ack", 32'(wb_ack), 32'd0);
    checkOutput("rst cfg_en", 32'(cfg_en), 32'd0);
    checkOutput("rst ufm_addr", 32'(ufm_addr), 32'd0);
    checkOutput("rst dat", 32'(wb_rdat), 32'd0);
    @(negedge clk);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    n_rst  = 1'b1;
    wb_write(CFGTXDR, OP_ENABLE);
    checkOutput("closed frame ignores tx", 32'(cfg_en), 32'd0);
    open_cmd(OP_ENABLE, 8'h08, 8'h00, 8'h00);
    close_frame();
    set_addr(14'd190);
    open_cmd(OP_READ_PAGE, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++)
      rx_read(8'(i), $sformatf("preserved %0d", i));
    close_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
